mprj_gate_sequencer: RTL and testbench

//  Consumes the user-area tie-high vector (user_hi) and sequences the management/user gating enables.

---
 rtl/mprj_gate_pkg.sv | 25 ++
 rtl/mprj_gate_sequencer_if.sv | 26 ++
 rtl/mprj_hi_debounce.sv | 42 ++++
 rtl/mprj_gate_sequencer.sv | 126 ++++++++++++
 tb/tb_mprj_gate_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mprj_gate_pkg.sv
// Shared types and default constants for the management/user gate sequencer.
package mprj_gate_pkg;

  localparam int unsigned DEF_HI_WIDTH    = 463;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DEBOUNCE    = 8;
  localparam int unsigned DEF_STEP_DELAY  = 16;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_EN_WB   = 3'd1,
    ST_EN_LA   = 3'd2,
    ST_EN_IRQ  = 3'd3,
    ST_ON      = 3'd4,
    ST_DIS_IRQ = 3'd5,
    ST_DIS_LA  = 3'd6,
    ST_DIS_WB  = 3'd7
  } gate_state_e;

  // Every state except the two resting ones is a timed sequence step.
  function automatic logic is_busy(gate_state_e s);
    return !(s == ST_OFF || s == ST_ON);
  endfunction

endpackage

// File: rtl/mprj_gate_sequencer_if.sv
// Tie-off vector, housekeeping controls and gate-enable outputs of the gate sequencer.
interface mprj_gate_sequencer_if
  import mprj_gate_pkg::*;
#(
  parameter int unsigned HI_WIDTH = DEF_HI_WIDTH
);
  logic [HI_WIDTH-1:0] user_hi;
  logic                mgmt_ena;
  logic                fault_clr;
  logic                user_powered;
  logic                wb_gate_en;
  logic                la_gate_en;
  logic                irq_gate_en;
  logic                seq_busy;
  logic                fault;

  modport master (
    output user_hi, mgmt_ena, fault_clr,
    input  user_powered, wb_gate_en, la_gate_en, irq_gate_en, seq_busy, fault
  );

  modport slave (
    input  user_hi, mgmt_ena, fault_clr,
    output user_powered, wb_gate_en, la_gate_en, irq_gate_en, seq_busy, fault
  );
endinterface

// File: rtl/mprj_hi_debounce.sv
// Level synchronizer followed by a saturating run-length counter; stable_o marks
// DEBOUNCE consecutive synchronized-high cycles.
module mprj_hi_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic level_i,
  output logic level_s_o,
  output logic stable_o
);
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sync_d = {sync_q[SYNC_STAGES-2:0], level_i};
    cnt_d  = cnt_q;
    if (!sync_q[SYNC_STAGES-1]) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(DEBOUNCE)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level_s_o = sync_q[SYNC_STAGES-1];
  assign stable_o  = (cnt_q == CW'(DEBOUNCE));
endmodule

// File: rtl/mprj_gate_sequencer.sv
// Confirms the user power domain via its tie-high vector, then raises wishbone, LA and
// IRQ gate enables in order and drops them in reverse.
module mprj_gate_sequencer
  import mprj_gate_pkg::*;
#(
  parameter int unsigned HI_WIDTH    = DEF_HI_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE,
  parameter int unsigned STEP_DELAY  = DEF_STEP_DELAY
) (
  input  logic                  clk,
  input  logic                  resetn,
  mprj_gate_sequencer_if.slave  bus
);
  localparam int unsigned SW = $clog2(STEP_DELAY + 1);

  logic [HI_WIDTH-1:0] user_hi;
  logic all_hi, part_hi;
  logic all_s, all_stable, part_s_unused, part_stable;

  gate_state_e state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic wb_q, wb_d, la_q, la_d, irq_q, irq_d, busy_q, busy_d, fault_q, fault_d;
  logic go_down, step_done;

  assign user_hi = bus.user_hi;
  assign all_hi  = &user_hi;
  assign part_hi = (|user_hi) & ~all_hi;

  mprj_hi_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_all_db (
    .clk(clk), .resetn(resetn), .level_i(all_hi),
    .level_s_o(all_s), .stable_o(all_stable)
  );

  mprj_hi_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_part_db (
    .clk(clk), .resetn(resetn), .level_i(part_hi),
    .level_s_o(part_s_unused), .stable_o(part_stable)
  );

  assign go_down   = ~bus.mgmt_ena | fault_q;
  assign step_done = (step_q == SW'(STEP_DELAY));

  always_comb begin
    state_d = state_q;
    wb_d    = wb_q;
    la_d    = la_q;
    irq_d   = irq_q;
    // A new partial-vector detection wins over a same-cycle clear.
    fault_d = part_stable | (fault_q & ~bus.fault_clr);

    // Losing the synchronized all-high level skips the orderly shutdown entirely.
    if (state_q != ST_OFF && !all_s) begin
      state_d = ST_OFF;
      wb_d    = 1'b0;
      la_d    = 1'b0;
      irq_d   = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: if (all_stable && bus.mgmt_ena && !fault_q) begin
          state_d = ST_EN_WB;
          wb_d    = 1'b1;
        end
        ST_EN_WB, ST_EN_LA, ST_EN_IRQ, ST_ON: begin
          if (go_down) begin
            state_d = ST_DIS_IRQ;
            irq_d   = 1'b0;
          end else if (step_done && state_q == ST_EN_WB) begin
            state_d = ST_EN_LA;
            la_d    = 1'b1;
          end else if (step_done && state_q == ST_EN_LA) begin
            state_d = ST_EN_IRQ;
            irq_d   = 1'b1;
          end else if (step_done && state_q == ST_EN_IRQ) begin
            state_d = ST_ON;
          end
        end
        ST_DIS_IRQ: if (step_done) begin
          state_d = ST_DIS_LA;
          la_d    = 1'b0;
        end
        ST_DIS_LA: if (step_done) begin
          state_d = ST_DIS_WB;
          wb_d    = 1'b0;
        end
        ST_DIS_WB: if (step_done) state_d = ST_OFF;
        default:   state_d = ST_OFF;
      endcase
    end

    if (state_d != state_q) begin
      step_d = SW'(1);
    end else if (step_done) begin
      step_d = step_q;
    end else begin
      step_d = step_q + 1'b1;
    end
    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_OFF;
      step_q  <= '0;
      wb_q    <= 1'b0;
      la_q    <= 1'b0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wb_q    <= wb_d;
      la_q    <= la_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign bus.user_powered = all_stable;
  assign bus.wb_gate_en   = wb_q;
  assign bus.la_gate_en   = la_q;
  assign bus.irq_gate_en  = irq_q;
  assign bus.seq_busy     = busy_q;
  assign bus.fault        = fault_q;
endmodule

// File: tb/tb_mprj_gate_sequencer.sv
// Self-checking bench for mprj_gate_sequencer: directed vector table, hand-written corner
// sequences, then random stimulus against a timestamp-based reference model.
module tb_mprj_gate_sequencer;
  import mprj_gate_pkg::*;

  localparam int HI_W = 463;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int SD   = 16;
  localparam int MAXN = 16384;

  localparam int PAT_ZERO = 0;
  localparam int PAT_ALL  = 1;
  localparam int PAT_PART = 2;

  localparam int P_OFF = 0, P_EN_WB = 1, P_EN_LA = 2, P_EN_IRQ = 3, P_ON = 4;
  localparam int P_DIS_IRQ = 5, P_DIS_LA = 6, P_DIS_WB = 7;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mprj_gate_sequencer_if #(.HI_WIDTH(HI_W)) bus ();

  mprj_gate_sequencer #(
    .HI_WIDTH(HI_W), .SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .STEP_DELAY(SD)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Output vector order: {user_powered, wb, la, irq, seq_busy, fault}
  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (pwr,wb,la,irq,busy,fault) at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.user_powered, bus.wb_gate_en, bus.la_gate_en, bus.irq_gate_en,
            bus.seq_busy, bus.fault};
  endfunction

  // ---------------- reference model ----------------
  // Edge-indexed history of the raw reductions and their run lengths; the sequencer
  // is tracked as a phase number plus the edge at which it was entered.
  bit m_raw_all [MAXN];
  int m_run_all [MAXN];
  int m_run_part[MAXN];
  int m_n, m_phase, m_entered;
  bit m_pw, m_fault, m_wb, m_la, m_irq;

  function automatic bit raw_all_at(int k);
    return (k < 1) ? 1'b0 : m_raw_all[k];
  endfunction
  function automatic int run_all_at(int k);
    return (k < 1) ? 0 : m_run_all[k];
  endfunction
  function automatic int run_part_at(int k);
    return (k < 1) ? 0 : m_run_part[k];
  endfunction

  task automatic model_reset();
    m_n = 0; m_phase = P_OFF; m_entered = 0;
    m_pw = 0; m_fault = 0; m_wb = 0; m_la = 0; m_irq = 0;
  endtask

  task automatic model_enter(input int p);
    m_phase   = p;
    m_entered = m_n;
    case (p)
      P_EN_WB:   m_wb  = 1;
      P_EN_LA:   m_la  = 1;
      P_EN_IRQ:  m_irq = 1;
      P_DIS_IRQ: m_irq = 0;
      P_DIS_LA:  m_la  = 0;
      P_DIS_WB:  m_wb  = 0;
      default: ;
    endcase
  endtask

  task automatic model_step();
    bit a, p, prev_pw, prev_fault, down;
    int elapsed;
    if (m_n >= MAXN - 2) begin
      $display("FAIL model_depth: got %0d expected below %0d", m_n, MAXN - 2);
      $fatal(1);
    end
    m_n++;
    a = &bus.user_hi;
    p = (|bus.user_hi) && !a;
    m_raw_all[m_n]  = a;
    m_run_all[m_n]  = a ? run_all_at(m_n - 1) + 1 : 0;
    m_run_part[m_n] = p ? run_part_at(m_n - 1) + 1 : 0;
    prev_pw    = m_pw;
    prev_fault = m_fault;

    if (m_phase != P_OFF && !raw_all_at(m_n - SYNC)) begin
      m_phase = P_OFF; m_entered = m_n;
      m_wb = 0; m_la = 0; m_irq = 0;
    end else begin
      elapsed = m_n - m_entered;
      down    = !bus.mgmt_ena || prev_fault;
      if (m_phase == P_OFF) begin
        if (prev_pw && bus.mgmt_ena && !prev_fault) model_enter(P_EN_WB);
      end else if (m_phase <= P_ON && down) begin
        model_enter(P_DIS_IRQ);
      end else if (m_phase != P_ON && elapsed >= SD) begin
        model_enter(m_phase == P_DIS_WB ? P_OFF : m_phase + 1);
      end
    end

    m_pw    = run_all_at(m_n - SYNC) >= DEB;
    m_fault = (run_part_at(m_n - 1 - SYNC) >= DEB) || (prev_fault && !bus.fault_clr);
  endtask

  function automatic logic [5:0] model_outs();
    bit busy;
    busy = (m_phase != P_OFF) && (m_phase != P_ON);
    return {m_pw, m_wb, m_la, m_irq, busy, m_fault};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      if (resetn) model_step();
      #1;
    end
  endtask

  task automatic set_hi(input int pat, input int bit_idx);
    case (pat)
      PAT_ALL:  bus.user_hi = '1;
      PAT_PART: begin
        bus.user_hi = '1;
        bus.user_hi[bit_idx] = 1'b0;
      end
      default:  bus.user_hi = '0;
    endcase
  endtask

  task automatic assert_reset();
    resetn = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int         pat;
    logic       mgmt;
    int         adv;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{PAT_ALL, 1'b1,  9, 6'b000000};
    vecs[1]  = '{PAT_ALL, 1'b1,  1, 6'b100000};
    vecs[2]  = '{PAT_ALL, 1'b1,  1, 6'b110010};
    vecs[3]  = '{PAT_ALL, 1'b1, 15, 6'b110010};
    vecs[4]  = '{PAT_ALL, 1'b1,  1, 6'b111010};
    vecs[5]  = '{PAT_ALL, 1'b1, 15, 6'b111010};
    vecs[6]  = '{PAT_ALL, 1'b1,  1, 6'b111110};
    vecs[7]  = '{PAT_ALL, 1'b1, 15, 6'b111110};
    vecs[8]  = '{PAT_ALL, 1'b1,  1, 6'b111100};
    vecs[9]  = '{PAT_ALL, 1'b0,  1, 6'b111010};
    vecs[10] = '{PAT_ALL, 1'b0, 15, 6'b111010};
    vecs[11] = '{PAT_ALL, 1'b0,  1, 6'b110010};
    vecs[12] = '{PAT_ALL, 1'b0, 15, 6'b110010};
    vecs[13] = '{PAT_ALL, 1'b0,  1, 6'b100010};
    vecs[14] = '{PAT_ALL, 1'b0, 15, 6'b100010};
    vecs[15] = '{PAT_ALL, 1'b0,  1, 6'b100000};
    vecs[16] = '{PAT_ALL, 1'b0,  4, 6'b100000};

    bus.user_hi   = '0;
    bus.mgmt_ena  = 1'b1;
    bus.fault_clr = 1'b0;
    assert_reset();
    tick(2);
    check("reset_state", outs(), 6'b000000);
    resetn = 1'b1;

    // Power-up ramp and orderly shutdown
    for (int i = 0; i < 17; i++) begin
      set_hi(vecs[i].pat, 0);
      bus.mgmt_ena = vecs[i].mgmt;
      tick(vecs[i].adv);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // mgmt_ena drops for one cycle in ON, returns during shutdown: finish, then restart
    bus.mgmt_ena = 1'b1;
    tick(1);  check("re_start", outs(), 6'b110010);
    tick(47); check("re_en_irq", outs(), 6'b111110);
    tick(1);  check("re_on", outs(), 6'b111100);
    bus.mgmt_ena = 1'b0;
    tick(1);  check("re_dis_irq", outs(), 6'b111010);
    bus.mgmt_ena = 1'b1;
    tick(15); check("re_dis_irq_hold", outs(), 6'b111010);
    tick(1);  check("re_dis_la", outs(), 6'b110010);
    tick(15); check("re_dis_la_hold", outs(), 6'b110010);
    tick(1);  check("re_dis_wb", outs(), 6'b100010);
    tick(15); check("re_dis_wb_hold", outs(), 6'b100010);
    tick(1);  check("re_off", outs(), 6'b100000);
    tick(1);  check("re_restart", outs(), 6'b110010);

    // Partial tie-off vector in EN_LA: immediate kill, fault after debounce
    tick(16); check("part_en_la", outs(), 6'b111010);
    set_hi(PAT_PART, 200);
    tick(SYNC);    check("part_before_kill", outs(), 6'b111010);
    tick(1);       check("part_kill", outs(), 6'b000000);
    tick(DEB - 1); check("part_no_fault_yet", outs(), 6'b000000);
    tick(1);       check("part_fault_set", outs(), 6'b000001);

    // Clear while partial persists: set wins; then restore and clear for real
    bus.fault_clr = 1'b1; tick(1); bus.fault_clr = 1'b0;
    check("clr_set_wins", outs(), 6'b000001);
    set_hi(PAT_ALL, 0);
    tick(12); check("fault_holds_off", outs(), 6'b100001);
    bus.fault_clr = 1'b1; tick(1); bus.fault_clr = 1'b0;
    check("fault_cleared", outs(), 6'b100000);
    tick(1);  check("clr_restart_wb", outs(), 6'b110010);
    tick(32); check("clr_restart_irq", outs(), 6'b111110);

    // Asynchronous reset in EN_IRQ, restart after release
    assert_reset();
    #2;      check("async_reset", outs(), 6'b000000);
    tick(2); check("reset_held", outs(), 6'b000000);
    resetn = 1'b1;
    tick(10); check("post_reset_powered", outs(), 6'b100000);
    tick(1);  check("post_reset_wb", outs(), 6'b110010);

    // Short all-high glitch must not power up
    set_hi(PAT_ZERO, 0);
    tick(SYNC + 1); check("glitch_pre_off", outs(), 6'b000000);
    set_hi(PAT_ALL, 0);
    tick(5);
    set_hi(PAT_ZERO, 0);
    for (int i = 0; i < 25; i++) begin
      tick(1);
      check($sformatf("glitch_c%0d", i), outs(), 6'b000000);
    end

    // Random stimulus against the reference model
    assert_reset();
    bus.mgmt_ena = 1'b1;
    set_hi(PAT_ALL, 0);
    tick(2);
    resetn = 1'b1;
    begin
      int hold = 0;
      int r;
      for (int c = 0; c < 3000; c++) begin
        if (hold == 0) begin
          r = int'($urandom_range(99));
          if (r < 60) begin
            set_hi(PAT_ALL, 0);
            hold = int'($urandom_range(200, 20));
          end else if (r < 80) begin
            set_hi(PAT_ZERO, 0);
            hold = int'($urandom_range(40, 1));
          end else begin
            set_hi(PAT_PART, int'($urandom_range(HI_W - 1)));
            hold = int'($urandom_range(40, 1));
          end
        end else begin
          hold--;
        end
        if ($urandom_range(79) == 0) bus.mgmt_ena = ~bus.mgmt_ena;
        bus.fault_clr = ($urandom_range(29) == 0);
        tick(1);
        check($sformatf("rand_c%0d", c), outs(), model_outs());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
